camera_fifo_read_arbiter: RTL and testbench
===========================================

Name: camera_fifo_read_arbiter

Overview:
- Shares the pixel-output path between the per-camera async pixel FIFOs (read side, PLL clock domain).
- Grants one camera at a time in round-robin order and issues FIFO reads in bursts of up to BURST_LEN bytes.
- Captures each byte after the FIFO's 1-cycle read latency, tags it with camera index and SOF, and presents it on a valid/ready byte stream to the downstream nibble/UART output stage.
- Replaces lockstep reading of both cameras, so one stalled camera no longer blocks the other.

Parameters:
- NUM_CAMERAS, 2, number of requesting FIFOs (≥2).
- BURST_LEN, 16, maximum reads issued per grant (1..255).
- OBUF_DEPTH, 4, output buffer entries (fixed 4; power of 2).

Ports:
- clock  in  1  PLL system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  arbitration enable; low finishes the current read and holds IDLE.
- fifo_rinc_o  out  NUM_CAMERAS  per-FIFO read strobe.
- fifo_rdata_i  in  NUM_CAMERAS×8  per-FIFO read data, valid the cycle after rinc.
- fifo_sof_i  in  NUM_CAMERAS  per-FIFO SOF bit, same timing as rdata.
- fifo_rempty_i  in  NUM_CAMERAS  per-FIFO empty flag, registered in the clock domain.
- out_valid_o  out  1  output byte valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  8  byte.
- out_cam_o  out  $clog2(NUM_CAMERAS)  source camera.
- out_sof_o  out  1  first pixel of a frame.
- busy_o  out  1  state≠IDLE, or reads in flight, or buffer non-empty.

Behaviour:
- Reset (asynchronous, reset_n low) values:
  - fifo_rinc_o=0, out_valid_o=0, out_data_o=0, out_cam_o=0, out_sof_o=0, busy_o=0.
  - state=IDLE, last_grant=NUM_CAMERAS-1 (camera 0 wins first), burst_cnt=0, inflight=0, buffer count=0.
- Reset mid-burst discards in-flight and buffered bytes; the FIFOs are not rewound.
- State machine has 2 states:
  - IDLE: if enable_i and any fifo_rempty_i[i]==0, pick the first non-empty index searching last_grant+1, +2, … (modulo NUM_CAMERAS). Register grant, set last_grant=grant and burst_cnt=0, go to BURST. Nothing eligible → stay.
  - BURST: fifo_rinc_o[grant]=1 iff fifo_rempty_i[grant]==0 && (count+inflight)<OBUF_DEPTH && burst_cnt<BURST_LEN && enable_i. burst_cnt increments on each issued read.
  - BURST → IDLE, in the first cycle where the read is not issued, on any of: burst_cnt==BURST_LEN, rempty[grant]==1, or enable_i==0.
  - A credit stall alone does not end the burst.
  - IDLE→BURST costs one cycle with no read. A lone eligible camera is re-granted after that gap.
- Read pipeline:
  - inflight (0/1) = registered copy of |fifo_rinc_o.
  - The cycle after a read, {rdata, sof, cam} of that read's camera is written into the output buffer.
  - At most one fifo_rinc_o bit is high in any cycle.
- Output buffer:
  - 4-entry FIFO; head drives out_*; out_valid_o = count≠0.
  - Pop on out_valid_o && out_ready_i. Push and pop in the same cycle leave count unchanged.
  - The credit rule guarantees no overflow. An overflow is an assertion failure.
  - out_* are held stable while valid && !ready.
  - Sustained throughput is 1 byte/cycle with ready held high.
- Ordering: bytes from one camera leave in FIFO order. Bursts leave in grant order, and bytes are never interleaved inside a burst.

Optional Feature:
- Macro: CAMERA_ARB_SOF_SYNC_EN.
- Defined:
  - Per-camera synced flag, cleared by reset.
  - Bytes read from an unsynced camera are consumed from the FIFO but not pushed; they still count toward burst_cnt and credit.
  - A byte with sof=1 sets synced and is pushed, so the first output byte per camera is an SOF.
- Undefined: all read bytes are pushed and no synced state exists.

Test Plan:
- Both FIFOs hold 40 bytes, ready=1, BURST_LEN=16 → cam0 bytes 0-15, cam1 0-15, cam0 16-31, cam1 16-31, cam0 32-39, cam1 32-39. Order preserved, one idle cycle per grant change.
- Only cam1 holds 5 bytes → 5 outputs with out_cam_o=1; fifo_rinc_o[0] never asserts; then IDLE and busy_o=0 after the last pop.
- Burst running, out_ready_i=0 for 10 cycles → reads stop after buffer count+inflight=4. out_data_o is stable for the whole stall; on release the output resumes with no loss or duplication.
- Cam0 empties after 3 bytes of a burst (rempty rises) → burst ends and the grant moves to cam1 on the next IDLE pass.
- reset_n pulsed low mid-burst with 3 bytes buffered → all outputs 0 immediately. After release, the first grant is cam0 and no stale bytes appear.
- CAMERA_ARB_SOF_SYNC_EN defined, cam0 FIFO = 7 non-SOF bytes then an SOF byte 0xA5 → first output is 0xA5 with out_sof_o=1, and the 7 leading bytes are drained without being output.

Source files
------------

// File: rtl/camera_fifo_read_arbiter.sv
// camera_fifo_read_arbiter
// Round-robin read arbiter for the per-camera async pixel FIFOs (read side,
// PLL clock domain). One camera is granted at a time and read in bursts of up
// to BURST_LEN bytes. Each byte is captured one cycle after its read strobe,
// tagged with camera index and SOF, and queued in a small output buffer that
// feeds a valid/ready byte stream.
//
// Ports:
//   clock, reset_n        : single clock, asynchronous active-low reset
//   enable_i              : arbitration enable (low: finish current read, idle)
//   fifo_rinc_o           : per-FIFO read strobe (at most one bit high)
//   fifo_rdata_i/sof_i    : per-FIFO read data + SOF, valid the cycle after rinc
//   fifo_rempty_i         : per-FIFO empty flag
//   out_valid_o/ready_i   : output byte handshake
//   out_data_o/cam_o/sof_o: byte, source camera, first-pixel-of-frame flag
//   busy_o                : not idle, read in flight, or buffer non-empty
//
// Optional feature (macro CAMERA_ARB_SOF_SYNC_EN): bytes from a camera are
// discarded until that camera delivers an SOF byte, so every camera's first
// output byte is an SOF.
module camera_fifo_read_arbiter #(
  parameter int NUM_CAMERAS = 2,
  parameter int BURST_LEN   = 16,
  parameter int OBUF_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable_i,
  output logic [NUM_CAMERAS-1:0]         fifo_rinc_o,
  input  logic [NUM_CAMERAS*8-1:0]       fifo_rdata_i,
  input  logic [NUM_CAMERAS-1:0]         fifo_sof_i,
  input  logic [NUM_CAMERAS-1:0]         fifo_rempty_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [7:0]                     out_data_o,
  output logic [$clog2(NUM_CAMERAS)-1:0] out_cam_o,
  output logic                           out_sof_o,
  output logic                           busy_o
);

  localparam int CW   = $clog2(NUM_CAMERAS);
  localparam int PW   = $clog2(OBUF_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CRW  = CNTW + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_grant, r_last_grant, w_grant_nxt;
  logic            w_found;
  logic [7:0]      r_burst_cnt;
  logic            r_inflight;
  logic [CW-1:0]   r_infl_cam;
  logic [7:0]      r_buf_data [OBUF_DEPTH];
  logic            r_buf_sof  [OBUF_DEPTH];
  logic [CW-1:0]   r_buf_cam  [OBUF_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CNTW-1:0] r_count;
  logic [CRW-1:0]  w_credit;
  logic            w_issue, w_push, w_pop;
  logic [7:0]      w_rdata;
  logic            w_rsof;

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
    return CW'((int'(base) + k) % NUM_CAMERAS);
  endfunction

  // Slots already committed: buffered bytes plus the read whose data lands next.
  assign w_credit = CRW'(r_count) + CRW'(r_inflight);
  assign w_issue  = (r_state == ST_BURST) && !fifo_rempty_i[r_grant] &&
                    (w_credit < CRW'(OBUF_DEPTH)) &&
                    (r_burst_cnt < 8'(BURST_LEN)) && enable_i;

  // Round-robin search starting just after the last granted camera.
  always_comb begin
    w_found     = 1'b0;
    w_grant_nxt = r_grant;
    for (int k = 1; k <= NUM_CAMERAS; k++) begin
      if (!w_found && !fifo_rempty_i[rr_idx(r_last_grant, k)]) begin
        w_found     = 1'b1;
        w_grant_nxt = rr_idx(r_last_grant, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fifo_rinc_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && w_found) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (w_issue) fifo_rinc_o[r_grant] = 1'b1;
        // A pure credit stall keeps the grant; only these end the burst.
        else if ((r_burst_cnt == 8'(BURST_LEN)) || fifo_rempty_i[r_grant] || !enable_i)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    w_rsof  = 1'b0;
    for (int i = 0; i < NUM_CAMERAS; i++) begin
      if (r_infl_cam == CW'(i)) begin
        w_rdata = fifo_rdata_i[i*8 +: 8];
        w_rsof  = fifo_sof_i[i];
      end
    end
  end

`ifdef CAMERA_ARB_SOF_SYNC_EN
  logic [NUM_CAMERAS-1:0] r_synced;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  r_synced             <= '0;
    else if (r_inflight && w_rsof) r_synced[r_infl_cam] <= 1'b1;
  end

  // Unsynced bytes are consumed (and used credit) but never enter the buffer.
  assign w_push = r_inflight && (r_synced[r_infl_cam] || w_rsof);
`else
  assign w_push = r_inflight;
`endif

  assign w_pop = (r_count != '0) && out_ready_i;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= CW'(NUM_CAMERAS - 1);
      r_burst_cnt  <= '0;
      r_inflight   <= 1'b0;
      r_infl_cam   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && enable_i && w_found) begin
        r_grant      <= w_grant_nxt;
        r_last_grant <= w_grant_nxt;
        r_burst_cnt  <= '0;
      end else if (w_issue) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
      r_inflight <= w_issue;
      r_infl_cam <= r_grant;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage carries no reset; outputs are masked while empty instead.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_buf_data[r_wptr] <= w_rdata;
      r_buf_sof[r_wptr]  <= w_rsof;
      r_buf_cam[r_wptr]  <= r_infl_cam;
    end
  end

  assign out_valid_o = (r_count != '0);
  assign out_data_o  = out_valid_o ? r_buf_data[r_rptr] : 8'd0;
  assign out_sof_o   = out_valid_o ? r_buf_sof[r_rptr]  : 1'b0;
  assign out_cam_o   = out_valid_o ? r_buf_cam[r_rptr]  : '0;
  assign busy_o      = (r_state != ST_IDLE) || r_inflight || out_valid_o;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == CNTW'(OBUF_DEPTH))));
`endif

endmodule

// File: tb/tb_camera_fifo_read_arbiter.sv
module tb_camera_fifo_read_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic [1:0]  fifo_rinc_o;
  logic [15:0] fifo_rdata_i;
  logic [1:0]  fifo_sof_i;
  logic [1:0]  fifo_rempty_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic [0:0]  out_cam_o;
  logic        out_sof_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  camera_fifo_read_arbiter #(
    .NUM_CAMERAS(2), .BURST_LEN(16), .OBUF_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable_i),
    .fifo_rinc_o(fifo_rinc_o), .fifo_rdata_i(fifo_rdata_i),
    .fifo_sof_i(fifo_sof_i), .fifo_rempty_i(fifo_rempty_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_cam_o(out_cam_o),
    .out_sof_o(out_sof_o), .busy_o(busy_o)
  );

  // Camera FIFO models: 1-cycle read latency, registered empty flag.
  logic [7:0] mem  [2][64];
  logic       msof [2][64];
  int         len  [2];
  int         ptr  [2];
  logic [7:0] rdq  [2];
  logic       sofq [2];
  logic       tb_clr = 1'b0;

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (tb_clr) ptr[i] <= 0;
      else if (fifo_rinc_o[i] && ptr[i] < 64) begin
        rdq[i]  <= mem[i][ptr[i]];
        sofq[i] <= msof[i][ptr[i]];
        ptr[i]  <= ptr[i] + 1;
      end
    end
  end

  always_comb begin
    fifo_rdata_i  = {rdq[1], rdq[0]};
    fifo_sof_i    = {sofq[1], sofq[0]};
    fifo_rempty_i = 2'b11;
    for (int i = 0; i < 2; i++) fifo_rempty_i[i] = (ptr[i] >= len[i]);
  end

  // Output monitor: records every accepted byte, sampled on the falling edge.
  logic [7:0] obs_data [128];
  logic       obs_cam  [128];
  logic       obs_sof  [128];
  int         n_obs = 0;
  logic       mon_clr = 1'b0;
  logic       rinc0_seen;
  logic       multi_rinc;

  always @(negedge clock) begin
    if (mon_clr) begin
      n_obs      <= 0;
      rinc0_seen <= 1'b0;
      multi_rinc <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i && n_obs < 128) begin
        obs_data[n_obs] <= out_data_o;
        obs_cam[n_obs]  <= out_cam_o[0];
        obs_sof[n_obs]  <= out_sof_o;
        n_obs           <= n_obs + 1;
      end
      if (fifo_rinc_o[0])        rinc0_seen <= 1'b1;
      if (fifo_rinc_o == 2'b11)  multi_rinc <= 1'b1;
    end
  end

  task automatic do_reset();
    reset_n     = 1'b0;
    enable_i    = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Empty both FIFO models, reload contents: cam0 byte k = k, cam1 = 0x80+k,
  // SOF on byte 0 of each.
  task automatic prep(input int n0, input int n1);
    enable_i = 1'b0;
    tb_clr   = 1'b1;
    mon_clr  = 1'b1;
    len[0]   = 0;
    len[1]   = 0;
    @(negedge clock);
    @(posedge clock);
    #1;
    tb_clr  = 1'b0;
    mon_clr = 1'b0;
    for (int k = 0; k < 64; k++) begin
      mem[0][k]  = 8'(k);
      msof[0][k] = (k == 0);
      mem[1][k]  = 8'(128 + k);
      msof[1][k] = (k == 0);
    end
    len[0] = n0;
    len[1] = n1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int c = 0; c < budget && n_obs < n; c++) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    enable_i    = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (fifo_rinc_o !== 2'b00) begin n_err++; $display("FAIL reset_rinc actual=%b required=00", fifo_rinc_o); end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid actual=%b required=0", out_valid_o); end
    n_cmp++; if (out_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data actual=%h required=00", out_data_o); end
    n_cmp++; if (out_cam_o !== 1'b0) begin n_err++; $display("FAIL reset_cam actual=%b required=0", out_cam_o); end
    n_cmp++; if (out_sof_o !== 1'b0) begin n_err++; $display("FAIL reset_sof actual=%b required=0", out_sof_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy_o); end
    reset_n = 1'b1;
    prep(0, 0);
    enable_i = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (busy_o !== 1'b0 || fifo_rinc_o !== 2'b00) begin n_err++; $display("FAIL empty_idle actual=busy %b rinc %b required=busy 0 rinc 00", busy_o, fifo_rinc_o); end
  endtask

  task automatic test_round_robin();
    int seg_start [6] = '{0, 16, 32, 48, 64, 72};
    int seg_k0    [6] = '{0, 0, 16, 16, 32, 32};
    int seg, k, cam;
    logic [9:0] got, req;
    do_reset();
    prep(40, 40);
    out_ready_i = 1'b1;
    enable_i    = 1'b1;
    wait_obs(80, 400);
    n_cmp++; if (n_obs !== 80) begin n_err++; $display("FAIL rr_count actual=%0d required=80", n_obs); end
    for (int j = 0; j < 80; j++) begin
      seg = 0;
      for (int s = 0; s < 6; s++) if (j >= seg_start[s]) seg = s;
      cam = seg % 2;
      k   = seg_k0[seg] + (j - seg_start[seg]);
      req = {cam[0], (k == 0), (cam == 1) ? 8'(128 + k) : 8'(k)};
      got = {obs_cam[j], obs_sof[j], obs_data[j]};
      n_cmp++; if (got !== req) begin n_err++; $display("FAIL rr_byte[%0d] actual=%03h required=%03h", j, got, req); end
    end
    n_cmp++; if (multi_rinc !== 1'b0) begin n_err++; $display("FAIL rr_onehot actual=%b required=0", multi_rinc); end
    repeat (4) @(posedge clock);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rr_busy_end actual=%b required=0", busy_o); end
  endtask

  task automatic test_single_cam();
    logic [9:0] got, req;
    do_reset();
    prep(0, 5);
    out_ready_i = 1'b1;
    enable_i    = 1'b1;
    wait_obs(5, 100);
    n_cmp++; if (n_obs !== 5) begin n_err++; $display("FAIL single_count actual=%0d required=5", n_obs); end
    for (int j = 0; j < 5; j++) begin
      req = {1'b1, (j == 0), 8'(128 + j)};
      got = {obs_cam[j], obs_sof[j], obs_data[j]};
      n_cmp++; if (got !== req) begin n_err++; $display("FAIL single_byte[%0d] actual=%03h required=%03h", j, got, req); end
    end
    @(posedge clock);
    #1;
    n_cmp++; if (rinc0_seen !== 1'b0) begin n_err++; $display("FAIL single_rinc0 actual=%b required=0", rinc0_seen); end
    n_cmp++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL single_idle actual=busy %b valid %b required=0 0", busy_o, out_valid_o); end
  endtask

  task automatic test_backpressure();
    int stall_bad = 0;
    logic [9:0] got, req;
    do_reset();
    prep(16, 0);
    out_ready_i = 1'b1;
    enable_i    = 1'b1;
    wait_obs(2, 100);
    out_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (out_data_o !== 8'h02 || out_valid_o !== 1'b1) stall_bad++;
    end
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_hold actual=%0d unstable cycles required=0", stall_bad); end
    n_cmp++; if (ptr[0] !== 6) begin n_err++; $display("FAIL bp_reads actual=%0d required=6", ptr[0]); end
    n_cmp++; if (fifo_rinc_o !== 2'b00) begin n_err++; $display("FAIL bp_rinc actual=%b required=00", fifo_rinc_o); end
    @(posedge clock);
    #1 out_ready_i = 1'b1;
    wait_obs(16, 200);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (n_obs !== 16) begin n_err++; $display("FAIL bp_count actual=%0d required=16", n_obs); end
    for (int j = 0; j < 16; j++) begin
      req = {1'b0, (j == 0), 8'(j)};
      got = {obs_cam[j], obs_sof[j], obs_data[j]};
      n_cmp++; if (got !== req) begin n_err++; $display("FAIL bp_byte[%0d] actual=%03h required=%03h", j, got, req); end
    end
  endtask

  task automatic test_cam_empty();
    logic [9:0] got, req;
    do_reset();
    prep(3, 4);
    out_ready_i = 1'b1;
    enable_i    = 1'b1;
    wait_obs(7, 100);
    n_cmp++; if (n_obs !== 7) begin n_err++; $display("FAIL empty_count actual=%0d required=7", n_obs); end
    for (int j = 0; j < 7; j++) begin
      if (j < 3) req = {1'b0, (j == 0), 8'(j)};
      else       req = {1'b1, (j == 3), 8'(128 + j - 3)};
      got = {obs_cam[j], obs_sof[j], obs_data[j]};
      n_cmp++; if (got !== req) begin n_err++; $display("FAIL empty_byte[%0d] actual=%03h required=%03h", j, got, req); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [9:0] got, req;
    int n_req;
    do_reset();
    prep(10, 10);
    out_ready_i = 1'b0;
    enable_i    = 1'b1;
    for (int c = 0; c < 50 && ptr[0] < 3; c++) begin
      @(posedge clock);
      #1;
    end
    n_cmp++; if (ptr[0] !== 3) begin n_err++; $display("FAIL mid_reads actual=%0d required=3", ptr[0]); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid_o, out_data_o, out_cam_o, out_sof_o, busy_o, fifo_rinc_o} !== 14'h0)
      begin n_err++; $display("FAIL mid_async_clear actual=v%b d%h c%b s%b b%b r%b required=all 0", out_valid_o, out_data_o, out_cam_o, out_sof_o, busy_o, fifo_rinc_o); end
    @(posedge clock);
    #1;
    reset_n     = 1'b1;
    out_ready_i = 1'b1;
`ifdef CAMERA_ARB_SOF_SYNC_EN
    n_req = 10;
`else
    n_req = 17;
`endif
    wait_obs(n_req, 200);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (n_obs !== n_req) begin n_err++; $display("FAIL mid_count actual=%0d required=%0d", n_obs, n_req); end
    for (int j = 0; j < n_req; j++) begin
`ifdef CAMERA_ARB_SOF_SYNC_EN
      req = {1'b1, (j == 0), 8'(128 + j)};
`else
      if (j < 7) req = {1'b0, 1'b0, 8'(j + 3)};
      else       req = {1'b1, (j == 7), 8'(128 + j - 7)};
`endif
      got = {obs_cam[j], obs_sof[j], obs_data[j]};
      n_cmp++; if (got !== req) begin n_err++; $display("FAIL mid_byte[%0d] actual=%03h required=%03h", j, got, req); end
    end
  endtask

  task automatic test_sof_sync();
    logic [9:0] got;
    do_reset();
    prep(0, 0);
    for (int k = 0; k < 7; k++) begin
      mem[0][k]  = 8'(16 + k);
      msof[0][k] = 1'b0;
    end
    mem[0][7]  = 8'hA5;
    msof[0][7] = 1'b1;
    mem[0][8]  = 8'h3C;
    msof[0][8] = 1'b0;
    len[0]     = 9;
    out_ready_i = 1'b1;
    enable_i    = 1'b1;
`ifdef CAMERA_ARB_SOF_SYNC_EN
    wait_obs(2, 100);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (n_obs !== 2) begin n_err++; $display("FAIL sync_count actual=%0d required=2", n_obs); end
    got = {obs_cam[0], obs_sof[0], obs_data[0]};
    n_cmp++; if (got !== 10'h1A5) begin n_err++; $display("FAIL sync_first actual=%03h required=1a5", got); end
    got = {obs_cam[1], obs_sof[1], obs_data[1]};
    n_cmp++; if (got !== 10'h03C) begin n_err++; $display("FAIL sync_second actual=%03h required=03c", got); end
`else
    wait_obs(9, 100);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (n_obs !== 9) begin n_err++; $display("FAIL nosync_count actual=%0d required=9", n_obs); end
    got = {obs_cam[0], obs_sof[0], obs_data[0]};
    n_cmp++; if (got !== 10'h010) begin n_err++; $display("FAIL nosync_first actual=%03h required=010", got); end
    got = {obs_cam[7], obs_sof[7], obs_data[7]};
    n_cmp++; if (got !== 10'h1A5) begin n_err++; $display("FAIL nosync_sof actual=%03h required=1a5", got); end
`endif
    n_cmp++; if (ptr[0] !== 9) begin n_err++; $display("FAIL sync_drained actual=%0d required=9", ptr[0]); end
  endtask

  initial begin
    reset_n     = 1'b0;
    enable_i    = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_round_robin();
    test_single_cam();
    test_backpressure();
    test_cam_empty();
    test_reset_midburst();
    test_sof_sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
